comb_mux_1b_128to1: RTL and testbench
=====================================

Name: comb_mux_1b_128to1

Overview:
- 1-bit-wide, 128-to-1 multiplexer: `out` equals the bit of `in_` indexed by `sel`.
- Purely combinational select path, used as a bit-select primitive inside datapath blocks.
- Also provides a registered copy of the selected bit for consumers that need a timing-clean version. This is the only clocked state.

Parameters:
- NUM_INPUTS, 128, number of 1-bit data inputs; must be a power of two.
- SEL_W, 7, select width; fixed at $clog2(NUM_INPUTS), not overridden independently.

Ports:
- clk  input  1  clock; used only by the out_q register.
- reset  input  1  asynchronous, active-low reset (0 = asserted); clears out_q only.
- in_  input  128  data inputs; bit i is data input i.
- sel  input  7  unsigned index of the selected input.
- out  output  1  combinational result, in_[sel].
- out_q  output  1  out registered on the rising edge of clk.

Behaviour:
- out = in_[sel] for every sel value 0..127. No clock involvement; zero-cycle latency.
- out must settle within the same cycle that in_ or sel changes.
- Every 7-bit sel value is legal, so there is no out-of-range case. A wider upstream index must be truncated to its low 7 bits before reaching sel.
- out ignores all bits of in_ other than bit sel. Example: in_ all ones except bit sel gives out = 0.
- out does not depend on reset. It stays valid and combinational while reset is asserted.
- out_q:
  - While reset = 0, out_q = 0 immediately (asynchronous clear).
  - On each rising edge of clk with reset = 1, out_q takes the current out.
  - Latency is 1 cycle.
  - When reset deasserts, out_q stays 0 until the first rising edge of clk after deassertion.
- X and Z handling: if sel contains X, out is X in simulation. No defaulting logic is permitted in the select path.
- Implementation: a balanced binary tree of 2:1 muxes, SEL_W levels deep.
  - Level k is steered by sel[k], where level 0 is nearest the inputs.
  - Each level halves the candidate count: 128 → 64 → … → 1.
  - The tree must be generated with generate loops, not written out by hand.
  - Functionally identical to an indexed part-select, in_[sel].

Decomposition:
- Shared package holds the constant NUM_INPUTS=128 and the derived SEL_W.
- One natural sub-module: mux2_1b, a 2:1 single-bit mux with ports a, b, s and y, where y = s ? b : a.
  - It is instantiated NUM_INPUTS-1 = 127 times via generate across SEL_W levels.
- The out_q flop lives in the top module. No further sub-modules.

Test Plan:
- Zero and single-bit walk: in_=0 with sel=0, 1, 2, 3 → out=0. in_=1<<sel for sel=0, 1, 2, 3 → out=1.
- High-index bits: in_=1<<15 with sel=15, in_=1<<100 with sel=100, in_=1<<127 with sel=127 → out=1 each. The same sel values with in_=0 → out=0.
- Isolation: in_=~(1<<42) with sel=42 → out=0. in_=1<<41 with sel=42 → out=0.
- Random: 20 vectors, each with in_ built from four 32-bit random words and sel set to the low 7 bits of a random 32-bit value → out == in_[sel], checked within the same cycle.
- Register and reset:
  - Hold reset=0 and toggle clk → out_q=0, while out still tracks in_[sel].
  - Release reset with in_=1<<5 and sel=5 → out_q=0 until the first rising edge of clk after release, then 1.
  - Change sel to 6 → out falls immediately; out_q falls at the next rising edge.
  - Assert reset mid-cycle → out_q=0 at once, without waiting for clk.

Source files
------------

// File: rtl/comb_mux_1b_128to1_pkg.sv
// Shared sizing constants for the 1-bit 128:1 select primitive and its mux tree.
package comb_mux_1b_128to1_pkg;

  localparam int MUX_NUM_INPUTS = 128;
  localparam int MUX_SEL_W      = $clog2(MUX_NUM_INPUTS);

  // Tree nodes are packed level by level: leaves first, root last.
  // Level k starts at 2n - (2n >> k), so level 0 starts at 0 and the root sits at 2n-2.
  function automatic int level_base(input int n, input int k);
    return (2 * n) - ((2 * n) >> k);
  endfunction

endpackage

// File: rtl/comb_mux_1b_128to1_mux2.sv
// Single-bit 2:1 mux leaf cell used to build the select tree.
module mux2_1b (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/comb_mux_1b_128to1.sv
// 1-bit 128:1 mux built as a balanced 2:1 tree, plus a registered copy of the result.
module comb_mux_1b_128to1
  import comb_mux_1b_128to1_pkg::*;
#(
  parameter int NUM_INPUTS = MUX_NUM_INPUTS,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] in_,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out,
  output logic                  out_q
);

  localparam int NODES = 2 * NUM_INPUTS - 1;

  logic [NODES-1:0] tree;
  logic             out_d;

  assign tree[NUM_INPUTS-1:0] = in_;

  // Level k+1 node j picks between level k nodes 2j (sel[k]=0) and 2j+1 (sel[k]=1).
  for (genvar k = 0; k < SEL_W; k++) begin : g_level
    localparam int SRC_BASE = level_base(NUM_INPUTS, k);
    localparam int DST_BASE = level_base(NUM_INPUTS, k + 1);
    for (genvar j = 0; j < (NUM_INPUTS >> (k + 1)); j++) begin : g_node
      mux2_1b u_mux2 (
        .a (tree[SRC_BASE + 2 * j]),
        .b (tree[SRC_BASE + 2 * j + 1]),
        .s (sel[k]),
        .y (tree[DST_BASE + j])
      );
    end
  end

  assign out = tree[NODES-1];

  always_comb begin
    out_d = out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_comb_mux_1b_128to1.sv
// Randomised self-checking bench for the 1-bit 128:1 mux and its registered output.
module tb_comb_mux_1b_128to1;

  logic         clk;
  logic         reset;
  logic [127:0] in_;
  logic [6:0]   sel;
  logic         out;
  logic         out_q;

  int n_tests;
  int n_fail;

  comb_mux_1b_128to1 dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected bit is whatever lands in position 0 after shifting right by sel.
  function automatic logic ref_bit(input logic [127:0] v, input logic [6:0] s);
    logic [127:0] sh;
    sh = v >> s;
    return sh[0];
  endfunction

  function automatic logic [127:0] onehot(input int idx);
    logic [127:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    logic exp;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_ = {$urandom, $urandom, $urandom, $urandom};
      sel = 7'($urandom);
      @(posedge clk);
      #1;
      exp = ref_bit(in_, sel);
      n_tests++;
      if (out_q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_q cycle %0d: got %b expected 0", i, out_q);
      end
      n_tests++;
      if (out !== exp) begin
        n_fail++;
        $display("FAIL reset_out_tracks cycle %0d sel=%0d: got %b expected %b", i, sel, out, exp);
      end
    end
  endtask

  task automatic test_walk();
    for (int s = 0; s < 4; s++) begin
      sel = 7'(s);
      in_ = '0;
      #1;
      n_tests++;
      if (out !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_zero sel=%0d: got %b expected 0", s, out);
      end
      in_ = onehot(s);
      #1;
      n_tests++;
      if (out !== 1'b1) begin
        n_fail++;
        $display("FAIL walk_one sel=%0d: got %b expected 1", s, out);
      end
    end
  endtask

  task automatic test_high_index();
    int idx [3] = '{15, 100, 127};
    for (int i = 0; i < 3; i++) begin
      sel = 7'(idx[i]);
      in_ = onehot(idx[i]);
      #1;
      n_tests++;
      if (out !== 1'b1) begin
        n_fail++;
        $display("FAIL high_one sel=%0d: got %b expected 1", idx[i], out);
      end
      in_ = '0;
      #1;
      n_tests++;
      if (out !== 1'b0) begin
        n_fail++;
        $display("FAIL high_zero sel=%0d: got %b expected 0", idx[i], out);
      end
    end
  endtask

  task automatic test_isolation();
    sel = 7'd42;
    in_ = ~onehot(42);
    #1;
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL isolate_all_but sel=42: got %b expected 0", out);
    end
    in_ = onehot(41);
    #1;
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL isolate_neighbour sel=42: got %b expected 0", out);
    end
  endtask

  task automatic test_random();
    logic exp;
    for (int i = 0; i < 20; i++) begin
      in_ = {$urandom, $urandom, $urandom, $urandom};
      sel = 7'($urandom & 32'h7f);
      #1;
      exp = ref_bit(in_, sel);
      n_tests++;
      if (out !== exp) begin
        n_fail++;
        $display("FAIL random vec %0d sel=%0d: got %b expected %b", i, sel, out, exp);
      end
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    in_ = onehot(5);
    sel = 7'd5;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL release_hold: got %b expected 0", out_q);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL release_first_edge: got %b expected 1", out_q);
    end
    sel = 7'd6;
    #1;
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_change_out: got %b expected 0", out);
    end
    n_tests++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_change_out_q_hold: got %b expected 1", out_q);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_change_out_q_edge: got %b expected 0", out_q);
    end
    sel = 7'd5;
    @(posedge clk);
    #2;
    n_tests++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_set: got %b expected 1", out_q);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got %b expected 0", out_q);
    end
    n_tests++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL out_during_reset: got %b expected 1", out);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_q;
    logic nxt;
    @(negedge clk);
    reset = 1'b1;
    exp_q = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_ = {$urandom, $urandom, $urandom, $urandom};
      sel = 7'($urandom);
      nxt = ref_bit(in_, sel);
      @(posedge clk);
      #1;
      exp_q = nxt;
      n_tests++;
      if (out_q !== exp_q) begin
        n_fail++;
        $display("FAIL b2b_out_q cycle %0d: got %b expected %b", i, out_q, exp_q);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    in_     = '0;
    sel     = '0;
    test_reset();
    test_walk();
    test_high_index();
    test_isolation();
    test_random();
    test_register();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
